// File: rtl/csr_pkg.sv
// Shared definitions for the CSR sequencer: FSM states, CSR map, funct3 codes
// and mstatus bit positions.
package csr_pkg;

  typedef enum logic [3:0] {
    IDLE, RMW_RD, RMW_WR,
    TRAP_EPC, TRAP_CAUSE, TRAP_STAT, TRAP_VEC,
    MRET_STAT, MRET_EPC
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [2:0] IDX_MSTATUS = 3'd0;
  localparam logic [2:0] IDX_MIE     = 3'd1;
  localparam logic [2:0] IDX_MTVEC   = 3'd2;
  localparam logic [2:0] IDX_MEPC    = 3'd3;
  localparam logic [2:0] IDX_MCAUSE  = 3'd4;
  localparam logic [2:0] IDX_MIP     = 3'd5;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Returns {hit, index}; hit is 0 for any unmapped address.
  function automatic logic [3:0] csr_decode(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS: csr_decode = {1'b1, IDX_MSTATUS};
      ADDR_MIE:     csr_decode = {1'b1, IDX_MIE};
      ADDR_MTVEC:   csr_decode = {1'b1, IDX_MTVEC};
      ADDR_MEPC:    csr_decode = {1'b1, IDX_MEPC};
      ADDR_MCAUSE:  csr_decode = {1'b1, IDX_MCAUSE};
      ADDR_MIP:     csr_decode = {1'b1, IDX_MIP};
      default:      csr_decode = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value computation for CSRRW/RS/RC and their immediate forms.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [4:0]      rs1_field,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] old_val,
  output logic [XLEN-1:0] new_val,
  output logic            we
);

  logic [XLEN-1:0] op;

  always_comb begin
    op      = funct3[2] ? XLEN'(rs1_field) : rs1_data;
    new_val = old_val;
    we      = 1'b0;
    case (funct3[1:0])
      F3_RW[1:0]: begin
        new_val = op;
        we      = 1'b1;
      end
      // Set/clear with a zero source field is a pure read.
      F3_RS[1:0]: begin
        new_val = old_val | op;
        we      = (rs1_field != 5'd0);
      end
      F3_RC[1:0]: begin
        new_val = old_val & ~op;
        we      = (rs1_field != 5'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// CSR instruction sequencer: read-modify-write of the CSR file plus the trap
// entry and MRET sequences, arbitrated in IDLE.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int NUM_CSR = 6,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  output logic            trap_ack,
  input  logic            mret_req,
  output logic            mret_ack,
  output logic [2:0]      csr_idx,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic            op_done,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  state_t          state, state_n;
  logic [19:0]     ir_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:2] tpc_q;
  logic [XLEN-1:0] tcause_q;

  logic [2:0]      funct3;
  logic [4:0]      rs1_field;
  logic [3:0]      dec;
  logic [2:0]      dec_idx;
  logic            legal;
  logic [XLEN-1:0] alu_new;
  logic            alu_we;
  logic            unused_bits;

  assign funct3      = ir_q[2:0];
  assign rs1_field   = ir_q[7:3];
  assign dec         = csr_decode(ir_q[19:8]);
  assign dec_idx     = dec[2:0];
  assign legal       = dec[3] && (int'(dec_idx) < NUM_CSR);
  assign unused_bits = ^{instruction[11:0], trap_pc[1:0]};

  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3   (funct3),
    .rs1_field(rs1_field),
    .rs1_data (rs1_q),
    .old_val  (old_q),
    .new_val  (alu_new),
    .we       (alu_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ir_q     <= '0;
      rs1_q    <= '0;
      old_q    <= '0;
      tpc_q    <= '0;
      tcause_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (trap_req) begin
          tpc_q    <= trap_pc[XLEN-1:2];
          tcause_q <= trap_cause;
        end else if (!mret_req && op_valid) begin
          ir_q  <= instruction[31:12];
          rs1_q <= rs1_data;
        end
      end
      if (state == RMW_RD) old_q <= csr_rdata;
    end
  end

  always_comb begin
    state_n        = state;
    op_ready       = 1'b0;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    csr_idx        = '0;
    csr_we         = 1'b0;
    csr_wdata      = '0;
    op_done        = 1'b0;
    rd_data        = '0;
    illegal        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      // State is forced to IDLE during reset; gating on rst keeps the
      // input-dependent handshakes low too.
      IDLE: if (rst) begin
        if (trap_req) begin
          trap_ack = 1'b1;
          state_n  = TRAP_EPC;
        end else if (mret_req) begin
          mret_ack = 1'b1;
          state_n  = MRET_STAT;
        end else begin
          op_ready = 1'b1;
          if (op_valid) state_n = RMW_RD;
        end
      end
      RMW_RD: begin
        csr_idx = legal ? dec_idx : '0;
        if (legal) state_n = RMW_WR;
        else begin
          illegal = 1'b1;
          state_n = IDLE;
        end
      end
      RMW_WR: begin
        csr_idx   = dec_idx;
        csr_we    = alu_we;
        csr_wdata = alu_new;
        op_done   = 1'b1;
        rd_data   = old_q;
        state_n   = IDLE;
      end
      TRAP_EPC: begin
        csr_idx   = IDX_MEPC;
        csr_we    = 1'b1;
        csr_wdata = {tpc_q, 2'b00};
        state_n   = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_idx   = IDX_MCAUSE;
        csr_we    = 1'b1;
        csr_wdata = tcause_q;
        state_n   = TRAP_STAT;
      end
      TRAP_STAT: begin
        csr_idx                                  = IDX_MSTATUS;
        csr_we                                   = 1'b1;
        csr_wdata                                = csr_rdata;
        csr_wdata[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
        csr_wdata[MSTATUS_MIE]                   = 1'b0;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        state_n                                  = TRAP_VEC;
      end
      TRAP_VEC: begin
        csr_idx        = IDX_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
        state_n        = IDLE;
      end
      MRET_STAT: begin
        csr_idx                 = IDX_MSTATUS;
        csr_we                  = 1'b1;
        csr_wdata               = csr_rdata;
        csr_wdata[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
        csr_wdata[MSTATUS_MPIE] = 1'b1;
        state_n                 = MRET_EPC;
      end
      MRET_EPC: begin
        csr_idx        = IDX_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl: stimulus pushes expected writes/completions/
// redirects, a negedge monitor pops and compares them against a CSR file model.
module tb_csr_ctrl;

  localparam int K_WR = 0, K_DONE = 1, K_ILL = 2, K_RED = 3;

  typedef struct {
    int          kind;
    logic [2:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready;
  logic [31:0] instruction, rs1_data;
  logic        trap_req, trap_ack, mret_req, mret_ack;
  logic [31:0] trap_cause, trap_pc;
  logic [2:0]  csr_idx;
  logic [31:0] csr_rdata, csr_wdata, rd_data, redirect_pc;
  logic        csr_we, op_done, illegal, redirect_valid;

  logic [31:0] csr_mem [6];
  logic        load_en;
  exp_t        sbq[$];
  int          acc_q[$];
  int          tests = 0, errors = 0;
  int          cyc = 0, last_redir = 0, ready_viol = 0;
  bit          trap_busy = 0;

  csr_ctrl #(.NUM_CSR(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .instruction(instruction), .rs1_data(rs1_data),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_ack(trap_ack),
    .mret_req(mret_req), .mret_ack(mret_ack),
    .csr_idx(csr_idx), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .op_done(op_done), .rd_data(rd_data), .illegal(illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR register file model with a combinational read port.
  assign csr_rdata = (csr_idx < 3'd6) ? csr_mem[csr_idx] : 32'h0;
  always @(posedge clk) begin
    if (load_en) begin
      csr_mem[0] <= 32'h8;   csr_mem[1] <= 32'h888; csr_mem[2] <= 32'h0;
      csr_mem[3] <= 32'h0;   csr_mem[4] <= 32'h0;   csr_mem[5] <= 32'h0;
    end else if (csr_we) csr_mem[csr_idx] <= csr_wdata;
  end

  function automatic logic [31:0] mk(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3);
    mk = {a, r, f3, 5'd1, 7'h73};
  endfunction

  task automatic exp_push(input int k, input logic [2:0] i, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.idx = i; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic sb_check(input int k, input logic [2:0] i, input logic [31:0] d);
    exp_t e;
    tests++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: kind %0d idx %0d data %h with nothing expected", k, i, d);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.idx !== i || e.data !== d) begin
        errors++;
        $display("FAIL sb_event: got kind %0d idx %0d data %h, expected kind %0d idx %0d data %h",
                 k, i, d, e.kind, e.idx, e.data);
      end
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  always @(negedge clk) begin
    int a;
    if (trap_busy && op_ready) ready_viol++;
    if (csr_we) sb_check(K_WR, csr_idx, csr_wdata);
    if (op_done) begin
      sb_check(K_DONE, 3'd0, rd_data);
      if (acc_q.size() != 0) begin
        a = acc_q.pop_front();
        // cyc+1 is the count after the rising edge that samples op_done.
        check("op_done_latency", 32'(cyc + 1 - a), 32'd2);
      end
    end
    if (illegal) begin
      sb_check(K_ILL, 3'd0, 32'h0);
      if (acc_q.size() != 0) void'(acc_q.pop_front());
    end
    if (redirect_valid) begin
      sb_check(K_RED, 3'd0, redirect_pc);
      last_redir = cyc;
    end
  end

  // Caller aligns to a falling edge; returns the cycle count after the accept edge.
  task automatic do_op(input logic [31:0] ins, input logic [31:0] d, output int acc);
    bit ok = 0;
    op_valid = 1'b1; instruction = ins; rs1_data = d;
    acc = 0;
    #1;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (op_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        acc_q.push_back(cyc);
        ok = 1;
      end else begin
        @(negedge clk); #1;
      end
    end
    op_valid = 1'b0;
    check("op_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause);
    bit got = 0;
    trap_busy = 1; trap_req = 1'b1; trap_pc = pc; trap_cause = cause;
    #1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (trap_ack) got = 1;
      else begin @(negedge clk); #1; end
    end
    check("trap_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    trap_req = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (redirect_valid) got = 1;
    end
    check("trap_redirect_seen", 32'(got), 32'd1);
    trap_busy = 0;
  endtask

  task automatic do_mret();
    bit got = 0;
    mret_req = 1'b1;
    #1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (mret_ack) got = 1;
      else begin @(negedge clk); #1; end
    end
    check("mret_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    mret_req = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (redirect_valid) got = 1;
    end
    check("mret_redirect_seen", 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, 32'({op_ready, trap_ack, mret_ack, csr_we, op_done, illegal,
                               redirect_valid, csr_idx}), 32'd0);
    check({name, "_data"}, csr_wdata | rd_data | redirect_pc, 32'd0);
  endtask

  initial begin
    int acc;
    rst = 1'b0; load_en = 1'b1;
    op_valid = 1'b1; trap_req = 1'b1; mret_req = 1'b1;
    instruction = mk(12'h300, 5'd1, 3'b001); rs1_data = 32'hFFFF_FFFF;
    trap_pc = 32'h0; trap_cause = 32'h0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    load_en = 1'b0; op_valid = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Read-modify-write forms
    exp_push(K_WR, 3'd2, 32'h8000_0100); exp_push(K_DONE, 3'd0, 32'h0);
    do_op(mk(12'h305, 5'd1, 3'b001), 32'h8000_0100, acc); @(negedge clk);
    exp_push(K_DONE, 3'd0, 32'h888);
    do_op(mk(12'h304, 5'd0, 3'b010), 32'h0000_FFFF, acc); @(negedge clk);
    exp_push(K_WR, 3'd1, 32'h8F8); exp_push(K_DONE, 3'd0, 32'h888);
    do_op(mk(12'h304, 5'd5, 3'b010), 32'h0F0, acc); @(negedge clk);
    exp_push(K_WR, 3'd1, 32'h8F0); exp_push(K_DONE, 3'd0, 32'h8F8);
    do_op(mk(12'h304, 5'd8, 3'b111), 32'hFFFF_FFFF, acc); @(negedge clk);
    exp_push(K_WR, 3'd5, 32'h1F); exp_push(K_DONE, 3'd0, 32'h0);
    do_op(mk(12'h344, 5'h1F, 3'b110), 32'h0, acc); @(negedge clk);
    exp_push(K_WR, 3'd5, 32'h1C); exp_push(K_DONE, 3'd0, 32'h1F);
    do_op(mk(12'h344, 5'd2, 3'b011), 32'h3, acc); @(negedge clk);
    drain();

    // Trap entry then MRET
    @(negedge clk);
    exp_push(K_WR, 3'd3, 32'h1000); exp_push(K_WR, 3'd4, 32'hB);
    exp_push(K_WR, 3'd0, 32'h1880); exp_push(K_RED, 3'd0, 32'h8000_0100);
    do_trap(32'h1002, 32'hB);
    @(negedge clk);
    exp_push(K_WR, 3'd0, 32'h1888); exp_push(K_RED, 3'd0, 32'h1000);
    do_mret();
    drain();

    // Unmapped address, then RWI with zero immediate still writes
    @(negedge clk);
    exp_push(K_ILL, 3'd0, 32'h0);
    do_op(mk(12'h7C0, 5'd1, 3'b001), 32'h1234, acc); @(negedge clk);
    exp_push(K_WR, 3'd4, 32'h0); exp_push(K_DONE, 3'd0, 32'hB);
    do_op(mk(12'h342, 5'd0, 3'b101), 32'hFFFF_FFFF, acc); @(negedge clk);
    drain();

    // Trap and op presented together: trap wins, op follows
    @(negedge clk);
    exp_push(K_WR, 3'd3, 32'h2004); exp_push(K_WR, 3'd4, 32'h7);
    exp_push(K_WR, 3'd0, 32'h1880); exp_push(K_RED, 3'd0, 32'h8000_0100);
    exp_push(K_WR, 3'd4, 32'h55); exp_push(K_DONE, 3'd0, 32'h7);
    op_valid = 1'b1; instruction = mk(12'h342, 5'd1, 3'b001); rs1_data = 32'h55;
    fork
      do_trap(32'h2004, 32'h7);
      begin
        #1 check("op_ready_vs_trap", 32'(op_ready), 32'd0);
        do_op(mk(12'h342, 5'd1, 3'b001), 32'h55, acc);
      end
    join
    check("op_after_redirect", 32'(acc > last_redir + 1), 32'd1);
    check("op_ready_during_trap", 32'(ready_viol), 32'd0);
    drain();

    // Reset while in TRAP_CAUSE
    @(negedge clk);
    exp_push(K_WR, 3'd3, 32'h3000);
    trap_req = 1'b1; trap_pc = 32'h3000; trap_cause = 32'h99;
    #1 check("trap_ack_rst_seq", 32'(trap_ack), 32'd1);
    @(posedge clk); #1 trap_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1 check_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    check("mcause_after_reset", csr_mem[4], 32'h55);
    rst = 1'b1;
    @(negedge clk);
    exp_push(K_WR, 3'd0, 32'h1888); exp_push(K_DONE, 3'd0, 32'h1880);
    do_op(mk(12'h300, 5'd3, 3'b010), 32'h8, acc); @(negedge clk);
    drain();

    check("final_mstatus", csr_mem[0], 32'h1888);
    check("final_mie",     csr_mem[1], 32'h8F0);
    check("final_mtvec",   csr_mem[2], 32'h8000_0100);
    check("final_mepc",    csr_mem[3], 32'h3000);
    check("final_mcause",  csr_mem[4], 32'h55);
    check("final_mip",     csr_mem[5], 32'h1C);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 Parameter: NUM_CSR, default 6, number of entries in the CSR register file sequenced by this block.
REQ-002 Parameter: XLEN, default 32, width of every data and PC port.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 op_valid  in  1  a CSR instruction is presented.
REQ-006 op_ready  out  1  the block can accept a CSR instruction this cycle.
REQ-007 instruction  in  32  SYSTEM-opcode instruction; funct3, csr, rs1/uimm and rd fields are decoded from it.
REQ-008 rs1_data  in  XLEN  rs1 operand value.
REQ-009 trap_req  in  1  trap request, held high until trap_ack.
REQ-010 trap_cause  in  XLEN  value written to mcause.
REQ-011 trap_pc  in  XLEN  value written to mepc.
REQ-012 trap_ack  out  1  one-cycle pulse: the trap was accepted.
REQ-013 mret_req  in  1  MRET request, held high until mret_ack.
REQ-014 mret_ack  out  1  one-cycle pulse: the MRET was accepted.
REQ-015 csr_idx  out  3  CSR file entry index (combinational read port and write port).
REQ-016 csr_rdata  in  XLEN  combinational read data for csr_idx.
REQ-017 csr_we  out  1  CSR file write enable.
REQ-018 csr_wdata  out  XLEN  CSR file write data.
REQ-019 op_done  out  1  one-cycle pulse: CSR instruction complete.
REQ-020 rd_data  out  XLEN  old CSR value; valid while op_done is high.
REQ-021 illegal  out  1  one-cycle pulse, in place of op_done, for an unmapped CSR address.
REQ-022 redirect_valid  out  1  one-cycle pulse: fetch redirect.
REQ-023 redirect_pc  out  XLEN  redirect target; valid while redirect_valid is high.

Function
REQ-024 CSR map: 0x300 mstatus=0, 0x304 mie=1, 0x305 mtvec=2, 0x341 mepc=3, 0x342 mcause=4, 0x344 mip=5; any other address is illegal.
REQ-025 FSM states: IDLE, RMW_RD, RMW_WR, TRAP_EPC, TRAP_CAUSE, TRAP_STAT, TRAP_VEC, MRET_STAT, MRET_EPC.
REQ-026 In IDLE, arbitration priority is trap_req, then mret_req, then op_valid.
REQ-027 op_ready = (state==IDLE) & ~trap_req & ~mret_req.
REQ-028 An op is accepted when op_valid & op_ready; instruction and rs1_data are registered on accept.
REQ-029 RMW_RD: csr_rdata for the decoded index is captured as the old value; an illegal address pulses illegal and returns to IDLE with no write.
REQ-030 RMW_WR: csr_we=1 with new value; op_done=1 with rd_data=old; next state IDLE.
REQ-031 Latency: op_done is asserted exactly 2 cycles after the accept edge.
REQ-032 New value by funct3 (op = rs1_data, or zero-extended 5-bit uimm for funct3[2]=1):
  - RW/RWI: new = op.
  - RS/RSI: new = old | op.
  - RC/RCI: new = old & ~op.
REQ-033 RS/RC/RSI/RCI with rs1/uimm field == 0 SHALL NOT assert csr_we; op_done still pulses.
REQ-034 Trap acceptance: trap_ack pulses in IDLE.
  - TRAP_EPC: write mepc = {trap_pc[XLEN-1:2], 2'b00}.
  - TRAP_CAUSE: write mcause = trap_cause.
  - TRAP_STAT: read mstatus; write it with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
  - TRAP_VEC: redirect_valid=1, redirect_pc = {mtvec[XLEN-1:2], 2'b00}; then IDLE.
REQ-035 MRET acceptance: mret_ack pulses in IDLE.
  - MRET_STAT: write mstatus with MIE=MPIE, MPIE=1.
  - MRET_EPC: redirect_valid=1, redirect_pc=mepc; then IDLE.
REQ-036 At most one CSR write per cycle; csr_we is never asserted in IDLE.
REQ-037 A trap_req rising while a sequence is in progress waits for IDLE; in-flight sequences are never aborted.

Reset
REQ-038 While rst=0: state=IDLE and every output is 0, including op_ready, csr_we, every pulse, and all data outputs.
REQ-039 Reset asserted mid-sequence abandons the sequence with no further csr_we; any CSR writes already issued remain.

Structure
REQ-040 Package csr_pkg holds the state enum, the CSR address constants and indices, the funct3 codes, and the mstatus bit positions.
REQ-041 The new-value computation (REQ-032/033) is a combinational sub-module named csr_alu.

Verification
REQ-042 CSRRW to mtvec with rs1_data=0x8000_0100 and old value 0 -> op_done 2 cycles after accept, rd_data=0, mtvec=0x8000_0100.
REQ-043 CSRRS to mie with rs1 field=x0 and mie=0x888 -> op_done, rd_data=0x888, csr_we never asserted.
REQ-044 Trap with mstatus=0x8, trap_pc=0x1002, cause=0xB, mtvec=0x8000_0100 -> mepc=0x1000, mcause=0xB, mstatus=0x1880, redirect_pc=0x8000_0100.
REQ-045 mret_req with mstatus=0x1880 and mepc=0x1000 -> mstatus=0x1888, redirect_pc=0x1000.
REQ-046 op_valid and trap_req asserted in the same cycle -> trap sequence first, op_ready=0 throughout, op accepted afterwards.
REQ-047 CSRRW to 0x7C0 -> illegal pulse, no csr_we; separately, rst=0 during TRAP_CAUSE -> IDLE, mcause unchanged.
